// File: rtl/tile_raster_sequencer.sv
// ---------------------------------------------------------------------------
// tile_raster_sequencer
//   Per-tile rasterizer controller. On a start request it looks up the bin's
//   list head, clears shader Z, then walks the bin's triangle list: each
//   record is bbox- and area-tested, survivors get 1/area from an external
//   pipelined divider and a start pulse to the pixel-shader array.
//
//   Optional feature macro: BACKFACE_CULL_EN (also reject negative area).
//
//   Ports
//     BOARD_CLK, RESET            clock, async active-high reset
//     startRasterizing            level start request, sampled in IDLE
//     rasterxOffset/rasteryOffset tile origin, captured on accept
//     headAddr / headPtr          head-table index out, head pointer back
//     binMemoryReadAddress        registered bin-memory address
//     binMemoryQ                  144-bit triangle record
//     divEn/divDenom/divQuotient  divider clken, signed area, quotient
//     areaRecip                   latched quotient, stable through SHADE
//     shaderStart/clearZ          shader array control
//     shadersDone                 per-shader done, all-ones = finished
//     doneRasterizing             tile finished, held until start drops
//     trisDrawn/trisCulled        saturating per-tile counters
//     walkOverflow                list-walk guard tripped this tile
// ---------------------------------------------------------------------------
module tile_raster_sequencer #(
    parameter int TILE_DIM    = 4,
    parameter int NANO_DIM    = 4,
    parameter int BIN_FACTOR  = 6,
    parameter int COORD_W     = 10,
    parameter int PTR_W       = 12,
    parameter int MEM_LAT     = 2,
    parameter int DIV_LAT     = 8,
    parameter int MAX_TRIS    = 1023,
    localparam int NUM_SHADERS = (TILE_DIM / NANO_DIM) ** 2,
    localparam int AREA_W      = 2 * COORD_W + 2,
    localparam int BIN_W       = COORD_W - BIN_FACTOR
) (
    input  logic                     BOARD_CLK,
    input  logic                     RESET,
    input  logic                     startRasterizing,
    input  logic [COORD_W-1:0]       rasterxOffset,
    input  logic [COORD_W-1:0]       rasteryOffset,
    output logic [2*BIN_W-1:0]       headAddr,
    input  logic [PTR_W-1:0]         headPtr,
    output logic [PTR_W-1:0]         binMemoryReadAddress,
    input  logic [143:0]             binMemoryQ,
    output logic                     divEn,
    output logic [AREA_W-1:0]        divDenom,
    input  logic [AREA_W-1:0]        divQuotient,
    output logic [AREA_W-1:0]        areaRecip,
    output logic                     shaderStart,
    output logic                     clearZ,
    input  logic [NUM_SHADERS-1:0]   shadersDone,
    output logic                     doneRasterizing,
    output logic [PTR_W-1:0]         trisDrawn,
    output logic [PTR_W-1:0]         trisCulled,
    output logic                     walkOverflow
);

    localparam int MC_W   = $clog2(MEM_LAT + 1);
    localparam int DC_W   = $clog2(DIV_LAT + 1);
    localparam int WALK_W = $clog2(MAX_TRIS + 1);
    localparam logic [MC_W-1:0]   MEM_LAT_C  = MC_W'(MEM_LAT);
    localparam logic [DC_W-1:0]   DIV_LAT_C  = DC_W'(DIV_LAT);
    localparam logic [WALK_W-1:0] MAX_TRIS_C = WALK_W'(MAX_TRIS);
    localparam logic [COORD_W:0]  TILE_SPAN  = (COORD_W+1)'(TILE_DIM - 1);

    typedef enum logic [3:0] {
        IDLE, HEAD, CLRZ, LOAD, TEST, RECIP, SHADE, NEXT, DONE
    } rasterState_e;

    rasterState_e state, stateNext;

    logic [COORD_W-1:0] offX, offY;
    logic [MC_W-1:0]    memCnt;
    logic [DC_W-1:0]    divCnt;
    logic [AREA_W-1:0]  areaReg;
    logic [WALK_W-1:0]  walked;
    logic [WALK_W-1:0]  walkedInc;
    // Shader-latency guard: fills with ones while in SHADE; bit 2 set means
    // the pulse cycle and two following cycles have passed.
    logic [2:0]         shadeVldPipe;

    logic accept, countCull, countDraw, stepNext, latchRecip;
    logic memReady, allDone, reject, faceCull, bboxCull;

    // ---- record decode ----------------------------------------------------
    logic [COORD_W-1:0] x0, y0, x1, y1, x2, y2;
    logic [PTR_W-1:0]   nextPtr;
    logic               unusedBits;

    assign x0      = binMemoryQ[9:0];
    assign y0      = binMemoryQ[19:10];
    assign x1      = binMemoryQ[45:36];
    assign y1      = binMemoryQ[55:46];
    assign x2      = binMemoryQ[81:72];
    assign y2      = binMemoryQ[91:82];
    assign nextPtr = binMemoryQ[143:132];
    assign unusedBits = ^{binMemoryQ[35:20], binMemoryQ[71:56],
                          binMemoryQ[107:92], binMemoryQ[131:108]};

    function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a, b, c);
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a, b, c);
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic signed [AREA_W-1:0] ext(input logic [COORD_W-1:0] v);
        return $signed({{(AREA_W-COORD_W){1'b0}}, v});
    endfunction

    // ---- bbox test, one extra bit so offset+TILE_DIM-1 cannot wrap ---------
    logic [COORD_W:0] minX, maxX, minY, maxY, tileEndX, tileEndY;

    assign minX     = {1'b0, min3(x0, x1, x2)};
    assign maxX     = {1'b0, max3(x0, x1, x2)};
    assign minY     = {1'b0, min3(y0, y1, y2)};
    assign maxY     = {1'b0, max3(y0, y1, y2)};
    assign tileEndX = {1'b0, offX} + TILE_SPAN;
    assign tileEndY = {1'b0, offY} + TILE_SPAN;
    assign bboxCull = (maxX < {1'b0, offX}) || (maxY < {1'b0, offY}) ||
                      (minX > tileEndX)     || (minY > tileEndY);

    // ---- signed area; the true value always fits AREA_W bits --------------
    logic signed [AREA_W-1:0] dxA, dyA, dxB, dyB, areaTest;

    assign dxA      = ext(x2) - ext(x0);
    assign dyA      = ext(y1) - ext(y0);
    assign dxB      = ext(x1) - ext(x0);
    assign dyB      = ext(y2) - ext(y0);
    assign areaTest = dxA * dyA - dyB * dxB;

`ifdef BACKFACE_CULL_EN
    assign faceCull = (areaTest == '0) || areaTest[AREA_W-1];
`else
    assign faceCull = (areaTest == '0);
`endif

    assign reject    = bboxCull || faceCull;
    assign memReady  = (memCnt >= MEM_LAT_C);
    assign allDone   = &shadersDone;
    assign walkedInc = walked + 1'b1;

    // The head table is read combinationally from the request in IDLE so the
    // pointer is back in time for HEAD.
    assign headAddr = (state == IDLE)
                    ? (startRasterizing ? {rasteryOffset[COORD_W-1:BIN_FACTOR],
                                           rasterxOffset[COORD_W-1:BIN_FACTOR]} : '0)
                    : {offY[COORD_W-1:BIN_FACTOR], offX[COORD_W-1:BIN_FACTOR]};

    assign divDenom = divEn ? areaReg : '0;

    // ---- FSM --------------------------------------------------------------
    always_ff @(posedge BOARD_CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext       = state;
        shaderStart     = 1'b0;
        clearZ          = 1'b0;
        divEn           = 1'b0;
        doneRasterizing = 1'b0;
        accept          = 1'b0;
        countCull       = 1'b0;
        countDraw       = 1'b0;
        stepNext        = 1'b0;
        latchRecip      = 1'b0;
        case (state)
            IDLE: if (startRasterizing) begin
                accept    = 1'b1;
                stateNext = HEAD;
            end
            HEAD: begin
                shaderStart = 1'b1;
                clearZ      = 1'b1;
                stateNext   = CLRZ;
            end
            CLRZ: begin
                clearZ = 1'b1;
                if (allDone && memReady)
                    stateNext = (binMemoryReadAddress == '0) ? DONE : LOAD;
            end
            LOAD: if (memReady) stateNext = TEST;
            TEST: begin
                if (reject) begin
                    countCull = 1'b1;
                    stateNext = NEXT;
                end else begin
                    stateNext = RECIP;
                end
            end
            RECIP: begin
                // DIV_LAT enabled cycles, then one cycle to capture the result.
                if (divCnt == DIV_LAT_C) begin
                    latchRecip = 1'b1;
                    stateNext  = SHADE;
                end else begin
                    divEn = 1'b1;
                end
            end
            SHADE: begin
                shaderStart = (shadeVldPipe == '0);
                if (shadeVldPipe[2] && allDone) begin
                    countDraw = 1'b1;
                    stateNext = NEXT;
                end
            end
            NEXT: begin
                stepNext = 1'b1;
                if (nextPtr == '0 || walkedInc == MAX_TRIS_C) stateNext = DONE;
                else                                          stateNext = LOAD;
            end
            DONE: begin
                doneRasterizing = 1'b1;
                if (!startRasterizing) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // ---- datapath -----------------------------------------------------------
    always_ff @(posedge BOARD_CLK or posedge RESET) begin
        if (RESET) begin
            offX                 <= '0;
            offY                 <= '0;
            binMemoryReadAddress <= '0;
            memCnt               <= '0;
            divCnt               <= '0;
            areaReg              <= '0;
            areaRecip            <= '0;
            walked               <= '0;
            shadeVldPipe         <= '0;
            trisDrawn            <= '0;
            trisCulled           <= '0;
            walkOverflow         <= 1'b0;
        end else begin
            if (!memReady) memCnt <= memCnt + 1'b1;
            if (accept) begin
                offX         <= rasterxOffset;
                offY         <= rasteryOffset;
                trisDrawn    <= '0;
                trisCulled   <= '0;
                walkOverflow <= 1'b0;
                walked       <= '0;
            end
            if (state == HEAD) begin
                binMemoryReadAddress <= headPtr;
                memCnt               <= '0;
            end
            if (state == TEST) begin
                areaReg <= areaTest;
                divCnt  <= '0;
            end
            if (divEn)      divCnt    <= divCnt + 1'b1;
            if (latchRecip) areaRecip <= divQuotient;
            shadeVldPipe <= (state == SHADE) ? {shadeVldPipe[1:0], 1'b1} : 3'b000;
            if (countCull && !(&trisCulled)) trisCulled <= trisCulled + 1'b1;
            if (countDraw && !(&trisDrawn))  trisDrawn  <= trisDrawn + 1'b1;
            if (stepNext) begin
                binMemoryReadAddress <= nextPtr;
                memCnt               <= '0;
                walked               <= walkedInc;
                if (nextPtr != '0 && walkedInc == MAX_TRIS_C) walkOverflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tile_raster_sequencer.sv
module tb_tile_raster_sequencer;
    localparam int COORD_W = 10;
    localparam int PTR_W   = 12;
    localparam int AREA_W  = 22;
    localparam int DIV_LAT = 8;
    localparam int MAX_T   = 4;

    logic               BOARD_CLK = 1'b0;
    logic               RESET = 1'b1;
    logic               startRasterizing;
    logic [COORD_W-1:0] rasterxOffset, rasteryOffset;
    logic [7:0]         headAddr;
    logic [PTR_W-1:0]   headPtr;
    logic [PTR_W-1:0]   binMemoryReadAddress;
    logic [143:0]       binMemoryQ;
    logic               divEn;
    logic [AREA_W-1:0]  divDenom, divQuotient, areaRecip;
    logic               shaderStart, clearZ;
    logic [0:0]         shadersDone;
    logic               doneRasterizing;
    logic [PTR_W-1:0]   trisDrawn, trisCulled;
    logic               walkOverflow;

    int checks = 0;
    int errors = 0;
    logic [AREA_W-1:0] sbQ[$];

    always #5 BOARD_CLK = ~BOARD_CLK;

    tile_raster_sequencer #(.MAX_TRIS(MAX_T)) dut (
        .BOARD_CLK(BOARD_CLK), .RESET(RESET),
        .startRasterizing(startRasterizing),
        .rasterxOffset(rasterxOffset), .rasteryOffset(rasteryOffset),
        .headAddr(headAddr), .headPtr(headPtr),
        .binMemoryReadAddress(binMemoryReadAddress), .binMemoryQ(binMemoryQ),
        .divEn(divEn), .divDenom(divDenom), .divQuotient(divQuotient),
        .areaRecip(areaRecip), .shaderStart(shaderStart), .clearZ(clearZ),
        .shadersDone(shadersDone), .doneRasterizing(doneRasterizing),
        .trisDrawn(trisDrawn), .trisCulled(trisCulled), .walkOverflow(walkOverflow)
    );

    // ---- environment models ----
    logic [143:0]     binMem [0:4095];
    logic [PTR_W-1:0] headTab [0:255];
    logic [143:0]     memStage;
    always @(posedge BOARD_CLK) begin
        memStage   <= binMem[binMemoryReadAddress];
        binMemoryQ <= memStage;
        headPtr    <= headTab[headAddr];
    end

    function automatic logic [AREA_W-1:0] recip(input logic [AREA_W-1:0] d);
        int dd;
        dd = int'($signed(d));
        if (dd == 0) return '0;
        return AREA_W'((2 ** (AREA_W - 1) - 1) / dd);
    endfunction

    logic [AREA_W-1:0] divPipe [0:DIV_LAT-1];
    always @(posedge BOARD_CLK) if (divEn) begin
        divPipe[0] <= recip(divDenom);
        for (int i = 1; i < DIV_LAT; i++) divPipe[i] <= divPipe[i-1];
    end
    assign divQuotient = divPipe[DIV_LAT-1];

    logic [1:0] shCnt = 2'd0;
    logic       shDone = 1'b1;
    always @(posedge BOARD_CLK) begin
        if (shaderStart) begin
            shCnt  <= 2'd3;
            shDone <= 1'b0;
        end else if (shCnt != 0) begin
            shCnt <= shCnt - 1'b1;
            if (shCnt == 2'd1) shDone <= 1'b1;
        end
    end
    assign shadersDone = shDone;

    // ---- helpers ----
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic addTri(input int addr, input int x0, y0, x1, y1, x2, y2, nxt, input bit drawn);
        logic [143:0] r;
        int a;
        r = '0;
        r[9:0] = 10'(x0);     r[19:10] = 10'(y0);    r[35:20] = 16'h1234;
        r[45:36] = 10'(x1);   r[55:46] = 10'(y1);    r[71:56] = 16'h5678;
        r[81:72] = 10'(x2);   r[91:82] = 10'(y2);    r[107:92] = 16'h9abc;
        r[131:108] = 24'habcdef; r[143:132] = 12'(nxt);
        binMem[addr] = r;
        a = (x2 - x0) * (y1 - y0) - (y2 - y0) * (x1 - x0);
        if (drawn) sbQ.push_back(AREA_W'(a));
    endtask

    task automatic runTile(input string tag, input int xo, yo, expDrawn, expCulled,
                           input logic expOvf, input bit dropEarly);
        int  pulses, divCyc;
        bit  seen, prevDiv;
        logic [AREA_W-1:0] expA;
        pulses = 0; divCyc = 0; seen = 0; prevDiv = 0;
        rasterxOffset = COORD_W'(xo);
        rasteryOffset = COORD_W'(yo);
        startRasterizing = 1'b1;
        #1;
        check({tag, "_headAddr"}, 32'(headAddr), 32'(((yo >> 6) << 4) | (xo >> 6)));
        for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
            @(negedge BOARD_CLK);
            if (dropEarly && cyc == 4) startRasterizing = 1'b0;
            if (divEn) begin
                divCyc++;
                if (!prevDiv && sbQ.size() != 0) check({tag, "_denom"}, 32'(divDenom), 32'(sbQ[0]));
            end
            prevDiv = divEn;
            if (shaderStart && !clearZ) begin
                pulses++;
                if (sbQ.size() == 0) check({tag, "_sb_empty"}, 32'(1), 32'(0));
                else begin
                    expA = sbQ.pop_front();
                    check({tag, "_recip"}, 32'(areaRecip), 32'(recip(expA)));
                end
            end
            if (doneRasterizing) begin
                seen = 1;
                check({tag, "_clearZ_done"}, 32'(clearZ), 32'(0));
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'(1));
        check({tag, "_drawn"}, 32'(trisDrawn), 32'(expDrawn));
        check({tag, "_culled"}, 32'(trisCulled), 32'(expCulled));
        check({tag, "_ovf"}, 32'(walkOverflow), 32'(expOvf));
        check({tag, "_pulses"}, 32'(pulses), 32'(expDrawn));
        check({tag, "_divCycles"}, 32'(divCyc), 32'(DIV_LAT * expDrawn));
        startRasterizing = 1'b0;
        for (int i = 0; i < 5 && doneRasterizing; i++) @(negedge BOARD_CLK);
        check({tag, "_done_clear"}, 32'(doneRasterizing), 32'(0));
    endtask

    // ---- directed sequence ----
    initial begin
        bit hit;
        for (int i = 0; i < 4096; i++) binMem[i] = '0;
        for (int i = 0; i < 256; i++) headTab[i] = '0;
        startRasterizing = 1'b0;
        rasterxOffset = '0;
        rasteryOffset = '0;
        repeat (3) @(negedge BOARD_CLK);
        RESET = 1'b0;
        @(negedge BOARD_CLK);
        check("rst_done",   32'(doneRasterizing), 0);
        check("rst_drawn",  32'(trisDrawn), 0);
        check("rst_culled", 32'(trisCulled), 0);
        check("rst_ovf",    32'(walkOverflow), 0);
        check("rst_ctrl",   32'({shaderStart, clearZ, divEn}), 0);
        check("rst_addr",   32'(binMemoryReadAddress), 0);
        check("rst_recip",  32'(areaRecip), 0);
        check("rst_head",   32'(headAddr), 0);

        // empty bin
        headTab[0] = '0;
        runTile("empty", 0, 0, 0, 0, 1'b0, 1'b0);

        // three overlapping triangles; start drops mid-walk
        headTab[8'h11] = 12'd10;
        addTri(10, 60, 60, 65, 70, 70, 62, 11, 1'b1);
        addTri(11, 64, 64, 64, 70, 70, 64, 12, 1'b1);
        addTri(12, 66, 60, 60, 68, 80, 66, 0, 1'b1);
        runTile("three", 64, 64, 3, 0, 1'b0, 1'b1);

        // bbox edges: maxX=63 culled, minX=68 culled, minX=67 drawn
        headTab[8'h11] = 12'd30;
        addTri(30, 0, 64, 63, 66, 10, 70, 31, 1'b0);
        addTri(31, 68, 64, 70, 66, 69, 70, 32, 1'b0);
        addTri(32, 67, 64, 67, 70, 75, 64, 0, 1'b1);
        runTile("bbox", 64, 64, 1, 2, 1'b0, 1'b0);

        // collinear (area 0) and minY beyond tile
        headTab[0] = 12'd40;
        addTri(40, 0, 0, 5, 5, 10, 10, 41, 1'b0);
        addTri(41, 0, 10, 2, 12, 1, 15, 0, 1'b0);
        runTile("zero", 0, 0, 0, 2, 1'b0, 1'b0);

        // clockwise triangle, area -50
        headTab[8'h11] = 12'd50;
`ifdef BACKFACE_CULL_EN
        addTri(50, 64, 64, 74, 64, 64, 69, 0, 1'b0);
        runTile("cw", 64, 64, 0, 1, 1'b0, 1'b0);
`else
        addTri(50, 64, 64, 74, 64, 64, 69, 0, 1'b1);
        runTile("cw", 64, 64, 1, 0, 1'b0, 1'b0);
        check("cw_recip_hold", 32'(areaRecip), 32'(recip(AREA_W'(-50))));
`endif

        // self-loop trips the walk guard after MAX_T records
        headTab[8'h11] = 12'd20;
        addTri(20, 0, 0, 10, 0, 0, 10, 20, 1'b0);
        runTile("loop", 64, 64, 0, MAX_T, 1'b1, 1'b0);
        @(negedge BOARD_CLK);
        check("hold_culled", 32'(trisCulled), 32'(MAX_T));
        check("hold_ovf",    32'(walkOverflow), 1);

        // reset while shading
        headTab[8'h11] = 12'd60;
        addTri(60, 64, 64, 64, 70, 70, 64, 0, 1'b1);
        rasterxOffset = 10'd64;
        rasteryOffset = 10'd64;
        startRasterizing = 1'b1;
        hit = 0;
        for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
            @(negedge BOARD_CLK);
            if (shaderStart && !clearZ) begin
                hit = 1;
                check("rstshade_recip", 32'(areaRecip), 32'(recip(sbQ.pop_front())));
            end
        end
        check("rstshade_reached", 32'(hit), 1);
        @(negedge BOARD_CLK);
        #2;
        startRasterizing = 1'b0;
        RESET = 1'b1;
        #1;
        check("rstshade_ctrl",  32'({doneRasterizing, clearZ, divEn, shaderStart}), 0);
        check("rstshade_drawn", 32'(trisDrawn), 0);
        check("rstshade_recip0", 32'(areaRecip), 0);
        check("rstshade_addr",  32'(binMemoryReadAddress), 0);
        check("rstshade_head",  32'(headAddr), 0);
        @(negedge BOARD_CLK);
        RESET = 1'b0;
        repeat (3) @(negedge BOARD_CLK);
        check("rstshade_idle", 32'({doneRasterizing, clearZ, shaderStart}), 0);
        check("sb_drained", 32'(sbQ.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
